// File: rtl/mmio_responder.sv
// rtl/mmio_responder.sv - I/O responder: HEX/LEDR/LEDG registers, synced KEY/SW reads with sticky key presses
// Optional debouncer on KEY/SW is enabled by defining MMIO_DEBOUNCE_EN.
module mmio_responder #(
  parameter int unsigned       DBITS           = 32,
  parameter logic [DBITS-1:0]  ADDR_HEX        = 32'hF0000000,
  parameter logic [DBITS-1:0]  ADDR_LEDR       = 32'hF0000004,
  parameter logic [DBITS-1:0]  ADDR_LEDG       = 32'hF0000008,
  parameter logic [DBITS-1:0]  ADDR_KEY        = 32'hF0000010,
  parameter logic [DBITS-1:0]  ADDR_SW         = 32'hF0000014,
  parameter int unsigned       DEBOUNCE_CYCLES = 500000,
  parameter int unsigned       DEB_BITS        = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrtEn,
  input  logic [DBITS-1:0] wrtData,
  input  logic             rdEn,
  output logic [DBITS-1:0] rdData,
  output logic             ioHit,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3
);

  localparam int NIN = 14;

  logic w_hit_hex, w_hit_ledr, w_hit_ledg, w_hit_key, w_hit_sw;
  logic w_clr;
  logic [NIN-1:0] w_raw;
  logic [NIN-1:0] w_level;
  logic [NIN-1:0] w_level_nxt;
  logic w_unused;

  logic [15:0]    r_hex;
  logic [9:0]     r_ledr;
  logic [7:0]     r_ledg;
  logic [3:0]     r_press;
  logic [NIN-1:0] r_sync1;
  logic [NIN-1:0] r_sync2;

  assign w_hit_hex  = (addr == ADDR_HEX);
  assign w_hit_ledr = (addr == ADDR_LEDR);
  assign w_hit_ledg = (addr == ADDR_LEDG);
  assign w_hit_key  = (addr == ADDR_KEY);
  assign w_hit_sw   = (addr == ADDR_SW);
  assign ioHit      = w_hit_hex | w_hit_ledr | w_hit_ledg | w_hit_key | w_hit_sw;
  assign w_clr      = rdEn & w_hit_key;

  // Keys are inverted on entry so every input bit is 1 = active from here on.
  assign w_raw = {SW, ~KEY};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

`ifdef MMIO_DEBOUNCE_EN
  localparam logic [DEB_BITS-1:0] LP_LAST = DEB_BITS'(DEBOUNCE_CYCLES - 1);

  logic [NIN-1:0]      r_deb;
  logic [DEB_BITS-1:0] r_cnt [NIN];
  logic [DEB_BITS-1:0] w_cnt_nxt [NIN];

  always_comb begin
    for (int i = 0; i < NIN; i++) begin
      w_level_nxt[i] = r_deb[i];
      w_cnt_nxt[i]   = '0;
      if (r_sync2[i] != r_deb[i]) begin
        if (r_cnt[i] == LP_LAST) w_level_nxt[i] = r_sync2[i];
        else                     w_cnt_nxt[i]   = r_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_deb <= '0;
      for (int i = 0; i < NIN; i++) r_cnt[i] <= '0;
    end else begin
      r_deb <= w_level_nxt;
      for (int i = 0; i < NIN; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  assign w_level  = r_deb;
  assign w_unused = ^wrtData[DBITS-1:16];
`else
  assign w_level     = r_sync2;
  assign w_level_nxt = r_sync1;
  assign w_unused    = ^{wrtData[DBITS-1:16], 32'(DEBOUNCE_CYCLES), 32'(DEB_BITS)};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hex   <= '0;
      r_ledr  <= '0;
      r_ledg  <= '0;
      r_press <= '0;
    end else begin
      if (wrtEn && w_hit_hex)  r_hex  <= wrtData[15:0];
      if (wrtEn && w_hit_ledr) r_ledr <= wrtData[9:0];
      if (wrtEn && w_hit_ledg) r_ledg <= wrtData[7:0];
      // A new rising level beats a clear-on-read on the same edge.
      r_press <= (r_press & ~{4{w_clr}}) | (w_level_nxt[3:0] & ~w_level[3:0]);
    end
  end

  always_comb begin
    rdData = '0;
    if (w_hit_hex)  rdData = DBITS'(r_hex);
    if (w_hit_ledr) rdData = DBITS'(r_ledr);
    if (w_hit_ledg) rdData = DBITS'(r_ledg);
    if (w_hit_key)  rdData = DBITS'({r_press, w_level[3:0]});
    if (w_hit_sw)   rdData = DBITS'(w_level[13:4]);
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  assign LEDR = r_ledr;
  assign LEDG = r_ledg;
  assign HEX0 = seg7(r_hex[3:0]);
  assign HEX1 = seg7(r_hex[7:4]);
  assign HEX2 = seg7(r_hex[11:8]);
  assign HEX3 = seg7(r_hex[15:12]);

endmodule
